dvi_video_gen: RTL and testbench

Parametrised video source for the DVI PMOD designs. It combines a resolution-configurable timing generator, a four-mode test-pattern engine and per-channel bit-depth reduction behind a fixed-latency pipeline. It drives the BML 3b (BPC=1) or 12b (BPC=4) HDMI PMOD directly from the pixel-clock domain. The top level only maps `vga_r/g/b`, `vga_de`, `vga_hs`, `vga_vs` and the pixel clock onto PMOD pins.

---
 rtl/dvi_video_gen_if.sv | 32 +++
 rtl/dvi_video_gen.sv | 173 +++++++++++++++++
 tb/tb_dvi_video_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dvi_video_gen_if.sv
// Video source bundle: pattern controls in, timed pixel stream out.
// Ports: mode/solid_rgb (to source); pix_x/y, frame_start, frame_cnt,
//        vga_de/hs/vs, vga_r/g/b (from source). master = source side.
interface dvi_video_gen_if #(
    parameter int CNT_W = 12,
    parameter int BPC   = 4
);
    logic [1:0]       mode;
    logic [23:0]      solid_rgb;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic             frame_start;
    logic [15:0]      frame_cnt;
    logic             vga_de;
    logic             vga_hs;
    logic             vga_vs;
    logic [BPC-1:0]   vga_r;
    logic [BPC-1:0]   vga_g;
    logic [BPC-1:0]   vga_b;

    modport master (
        input  mode, solid_rgb,
        output pix_x, pix_y, frame_start, frame_cnt,
        output vga_de, vga_hs, vga_vs, vga_r, vga_g, vga_b
    );

    modport slave (
        output mode, solid_rgb,
        input  pix_x, pix_y, frame_start, frame_cnt,
        input  vga_de, vga_hs, vga_vs, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/dvi_video_gen.sv
// Timing generator + test-pattern engine + bit-depth reduction, 2-cycle latency.
// Ports: clk_dot (pixel clock), reset (async, active high),
//        vid (dvi_video_gen_if.master: controls in, video stream out).
module dvi_video_gen #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   BPC      = 4,
    parameter int   CHK_LOG2 = 5,
    parameter int   CNT_W    = 12
) (
    input logic             clk_dot,
    input logic             reset,
    dvi_video_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

    // stage 0
    logic [CNT_W-1:0] h, v, bar_cnt;
    logic [2:0]       bar_idx;
    logic [1:0]       mode_sh;
    logic [23:0]      rgb_sh;

    logic             at_origin, active0, hs0, vs0;
    logic [1:0]       mode_eff;
    logic [23:0]      solid_eff;
    logic [7:0]       pr, pg, pb, hv_sum;

    // stage 1
    logic [7:0]       r1, g1, b1;
    logic             de1, hs1, vs1, fs1;
    logic [CNT_W-1:0] x1, y1;

    assign at_origin = (h == '0) && (v == '0);
    assign active0   = (h < H_ACT) && (v < V_ACT);
    assign hs0       = (h >= HS_BEG) && (h < HS_END);
    assign vs0       = (v >= VS_BEG) && (v < VS_END);

    // The frame's first pixel must already see a value changed at (0,0),
    // so bypass the shadow in that one cycle.
    assign mode_eff  = at_origin ? vid.mode      : mode_sh;
    assign solid_eff = at_origin ? vid.solid_rgb : rgb_sh;

    always_ff @(posedge clk_dot or posedge reset) begin
        if (reset) begin
            h       <= '0;
            v       <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            mode_sh <= '0;
            rgb_sh  <= '0;
        end else begin
            if (at_origin) begin
                mode_sh <= vid.mode;
                rgb_sh  <= vid.solid_rgb;
            end
            if (h == H_LAST) begin
                h       <= '0;
                bar_cnt <= '0;
                bar_idx <= '0;
                v       <= (v == V_LAST) ? '0 : v + ONE;
            end else begin
                h <= h + ONE;
                // Bar index steps every BAR_W active pixels; avoids a divider.
                if (h < H_ACT) begin
                    if (bar_cnt == BAR_LAST) begin
                        bar_cnt <= '0;
                        bar_idx <= bar_idx + 3'd1;
                    end else begin
                        bar_cnt <= bar_cnt + ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        pr     = '0;
        pg     = '0;
        pb     = '0;
        hv_sum = h[7:0] + v[7:0];
        if (active0) begin
            unique case (mode_eff)
                // Colour bar order W,Y,C,G,M,R,B,K maps to inverted index bits.
                2'd0: begin
                    pr = {8{~bar_idx[1]}};
                    pg = {8{~bar_idx[2]}};
                    pb = {8{~bar_idx[0]}};
                end
                2'd1: begin
                    pr = h[7:0];
                    pg = v[7:0];
                    pb = hv_sum;
                end
                2'd2: {pr, pg, pb} = {24{h[CHK_LOG2] ^ v[CHK_LOG2]}};
                default: {pr, pg, pb} = solid_eff;
            endcase
        end
    end

    always_ff @(posedge clk_dot or posedge reset) begin
        if (reset) begin
            r1  <= '0;
            g1  <= '0;
            b1  <= '0;
            de1 <= 1'b0;
            hs1 <= 1'b0;
            vs1 <= 1'b0;
            fs1 <= 1'b0;
            x1  <= '0;
            y1  <= '0;
        end else begin
            r1  <= pr;
            g1  <= pg;
            b1  <= pb;
            de1 <= active0;
            hs1 <= hs0;
            vs1 <= vs0;
            fs1 <= at_origin;
            x1  <= h;
            y1  <= v;
        end
    end

    // stage 2: polarity and truncation applied here only
    always_ff @(posedge clk_dot or posedge reset) begin
        if (reset) begin
            vid.vga_r       <= '0;
            vid.vga_g       <= '0;
            vid.vga_b       <= '0;
            vid.vga_de      <= 1'b0;
            vid.vga_hs      <= ~HS_POL;
            vid.vga_vs      <= ~VS_POL;
            vid.frame_start <= 1'b0;
            vid.frame_cnt   <= '0;
            vid.pix_x       <= '0;
            vid.pix_y       <= '0;
        end else begin
            vid.vga_r       <= r1[7 -: BPC];
            vid.vga_g       <= g1[7 -: BPC];
            vid.vga_b       <= b1[7 -: BPC];
            vid.vga_de      <= de1;
            vid.vga_hs      <= hs1 ? HS_POL : ~HS_POL;
            vid.vga_vs      <= vs1 ? VS_POL : ~VS_POL;
            vid.frame_start <= fs1;
            vid.pix_x       <= x1;
            vid.pix_y       <= y1;
            if (fs1) begin
                vid.frame_cnt <= vid.frame_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_dvi_video_gen.sv
// Randomised check of dvi_video_gen against a linear-timeline model.
// Three instances: BPC=4 active-high, BPC=8 active-low, BPC=1.
module tb_dvi_video_gen;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int CL = 2;

    localparam logic [23:0] BAR_C [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    logic        clk_dot = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = '0;
    logic [23:0] solid_rgb = '0;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int de_cnt = 0;
    int last_fs = 0;

    logic [1:0]  mode_hist  [0:4095];
    logic [23:0] solid_hist [0:4095];

    always #5 clk_dot = ~clk_dot;

    dvi_video_gen_if #(.CNT_W(12), .BPC(4)) if_a ();
    dvi_video_gen_if #(.CNT_W(12), .BPC(8)) if_b ();
    dvi_video_gen_if #(.CNT_W(12), .BPC(1)) if_c ();

    assign if_a.mode = mode;
    assign if_b.mode = mode;
    assign if_c.mode = mode;
    assign if_a.solid_rgb = solid_rgb;
    assign if_b.solid_rgb = solid_rgb;
    assign if_c.solid_rgb = solid_rgb;

    dvi_video_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .BPC(4), .CHK_LOG2(CL), .CNT_W(12)
    ) u_a (.clk_dot(clk_dot), .reset(reset), .vid(if_a));

    dvi_video_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .BPC(8), .CHK_LOG2(CL), .CNT_W(12)
    ) u_b (.clk_dot(clk_dot), .reset(reset), .vid(if_b));

    dvi_video_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .BPC(1), .CHK_LOG2(CL), .CNT_W(12)
    ) u_c (.clk_dot(clk_dot), .reset(reset), .vid(if_c));

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    // 8-bit pattern for linear output index p (p=0 is frame 0 pixel (0,0)).
    function automatic logic [23:0] pat(int p);
        int hh, vv, f;
        logic [1:0]  m;
        logic [23:0] s;
        hh = p % HT;
        vv = (p / HT) % VT;
        f  = p / FT;
        m  = mode_hist[f * FT + 1];
        s  = solid_hist[f * FT + 1];
        if (hh >= HA || vv >= VA) return 24'h0;
        case (m)
            2'd0: return BAR_C[hh / (HA / 8)];
            2'd1: return {8'(hh), 8'(vv), 8'(hh + vv)};
            2'd2: return (((hh >> CL) ^ (vv >> CL)) & 1) != 0 ?
                         24'hFFFFFF : 24'h0;
            default: return s;
        endcase
    endfunction

    function automatic logic [63:0] rgb_exp(int kk, int bpc);
        logic [23:0] c;
        if (kk < 2) return 64'h0;
        c = pat(kk - 2);
        return 64'({8'(c[23:16] >> (8 - bpc)),
                    8'(c[15:8]  >> (8 - bpc)),
                    8'(c[7:0]   >> (8 - bpc))});
    endfunction

    function automatic logic [63:0] tim_exp(int kk, logic hp, logic vp);
        int p, hh, vv, f;
        logic de, hsi, vsi, fs;
        if (kk < 2)
            return 64'({12'd0, 12'd0, 1'b0, 16'd0, 1'b0, ~hp, ~vp});
        p   = kk - 2;
        hh  = p % HT;
        vv  = (p / HT) % VT;
        f   = p / FT;
        de  = (hh < HA) && (vv < VA);
        hsi = (hh >= HA + HF) && (hh < HA + HF + HS);
        vsi = (vv >= VA + VF) && (vv < VA + VF + VS);
        fs  = (p % FT) == 0;
        return 64'({12'(hh), 12'(vv), fs, 16'(f + 1), de,
                    hsi ? hp : ~hp, vsi ? vp : ~vp});
    endfunction

    task automatic check_all(input int kk);
        check("a_tim", 64'({if_a.pix_x, if_a.pix_y, if_a.frame_start,
              if_a.frame_cnt, if_a.vga_de, if_a.vga_hs, if_a.vga_vs}),
              tim_exp(kk, 1'b1, 1'b1));
        check("b_tim", 64'({if_b.pix_x, if_b.pix_y, if_b.frame_start,
              if_b.frame_cnt, if_b.vga_de, if_b.vga_hs, if_b.vga_vs}),
              tim_exp(kk, 1'b0, 1'b0));
        check("c_tim", 64'({if_c.pix_x, if_c.pix_y, if_c.frame_start,
              if_c.frame_cnt, if_c.vga_de, if_c.vga_hs, if_c.vga_vs}),
              tim_exp(kk, 1'b1, 1'b1));
        check("a_rgb", 64'({8'(if_a.vga_r), 8'(if_a.vga_g), 8'(if_a.vga_b)}),
              rgb_exp(kk, 4));
        check("b_rgb", 64'({if_b.vga_r, if_b.vga_g, if_b.vga_b}),
              rgb_exp(kk, 8));
        check("c_rgb", 64'({8'(if_c.vga_r), 8'(if_c.vga_g), 8'(if_c.vga_b)}),
              rgb_exp(kk, 1));
    endtask

    // Inputs that the coming frame f will latch at its (0,0).
    task automatic frame_inputs(input int f);
        case (f)
            0: mode = 2'd0;
            1: mode = 2'd1;
            2: mode = 2'd2;
            3: begin mode = 2'd3; solid_rgb = 24'hA5C37E; end
            4: begin mode = 2'd3; solid_rgb = 24'h000000; end
            default: begin
                mode = 2'($urandom_range(0, 3));
                solid_rgb = 24'($urandom);
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk_dot);
        k++;
        mode_hist[k]  = mode;
        solid_hist[k] = solid_rgb;
        @(negedge clk_dot);
        check_all(k);
        if (k >= 2 && k - 2 < FT) de_cnt += int'(if_a.vga_de);
        if (k == FT + 1) check("de_cnt", 64'(de_cnt), 64'(8 * HA));
        if (if_a.frame_start) begin
            if (last_fs == 0) check("fs_first", 64'(k), 64'd2);
            else check("fs_gap", 64'(k - last_fs), 64'(FT));
            last_fs = k;
        end
        if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 99) == 0) solid_rgb = 24'($urandom);
        if (k == FT + 3 * HT + 5) mode = 2'd2;
        if (k % FT == 0) frame_inputs(k / FT);
    endtask

    task automatic release_reset();
        @(negedge clk_dot);
        reset   = 1'b0;
        k       = 0;
        de_cnt  = 0;
        last_fs = 0;
        frame_inputs(0);
    endtask

    initial begin
        solid_rgb = 24'($urandom);
        repeat (3) begin
            @(negedge clk_dot);
            check_all(0);
        end
        release_reset();
        repeat (10 * FT) step();
        while (((k - 2) % FT) / HT != 5) step();
        #1 reset = 1'b1;
        #1 check_all(0);
        repeat (3) begin
            @(negedge clk_dot);
            check_all(0);
        end
        release_reset();
        repeat (2 * FT + 10) step();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
